// File: rtl/calc_pkg.sv
// Shared types and widths for the calc1 request sequencers and the four-port wrapper.
package calc_pkg;

  localparam int unsigned CmdW  = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned RespW = 2;

  typedef enum logic [CmdW-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [RespW-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_INT  = 2'd3
  } calc_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StSendOp1,
    StSendOp2,
    StWaitResp,
    StHoldResp
  } seq_state_e;

endpackage

// File: rtl/calc_req_sequencer.sv
// Serialises one calculator transaction onto a calc1 request port and returns its
// response (or a timeout) on a valid/ready interface. All outputs are registered.
module calc_req_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CmdW-1:0]  in_cmd,
  input  logic [DataW-1:0] in_op1,
  input  logic [DataW-1:0] in_op2,
  output logic [CmdW-1:0]  req_cmd_out,
  output logic [DataW-1:0] req_data_out,
  input  logic [RespW-1:0] calc_resp,
  input  logic [DataW-1:0] calc_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RespW-1:0] rsp_code,
  output logic [DataW-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             spurious,
  output logic [15:0]      txn_count
);

  localparam int unsigned      TimerW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLimit = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerMax   = '1;

  seq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [DataW-1:0]  op2_q, op2_d;
  logic              in_ready_q, in_ready_d;
  logic [CmdW-1:0]   req_cmd_q, req_cmd_d;
  logic [DataW-1:0]  req_data_q, req_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RespW-1:0]  rsp_code_q, rsp_code_d;
  logic [DataW-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              spurious_q, spurious_d;
  logic [15:0]       txn_count_q, txn_count_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    op2_d         = op2_q;
    req_cmd_d     = '0;
    req_data_d    = '0;
    rsp_valid_d   = rsp_valid_q;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_count_d   = txn_count_q;
    // Any response outside the wait window is a protocol error seen on the port.
    spurious_d    = spurious_q | ((state_q != StWaitResp) && (calc_resp != '0));

    unique case (state_q)
      StIdle: begin
        // A no-op is consumed here and never reaches the port.
        if (in_valid && in_ready_q && (in_cmd != CMD_NOP)) begin
          op2_d      = in_op2;
          req_cmd_d  = in_cmd;
          req_data_d = in_op1;
          state_d    = StSendOp1;
        end
      end
      StSendOp1: begin
        req_data_d = op2_q;
        state_d    = StSendOp2;
      end
      StSendOp2: begin
        timer_d = '0;
        state_d = StWaitResp;
      end
      StWaitResp: begin
        if (calc_resp != '0) begin
          rsp_valid_d   = 1'b1;
          rsp_code_d    = calc_resp;
          rsp_data_d    = calc_data;
          rsp_timeout_d = 1'b0;
          state_d       = StHoldResp;
        end else if (timer_q == TimerLimit) begin
          rsp_valid_d   = 1'b1;
          rsp_code_d    = '0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = StHoldResp;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHoldResp: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          txn_count_d   = txn_count_q + 16'd1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      op2_q         <= '0;
      in_ready_q    <= 1'b0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      spurious_q    <= 1'b0;
      txn_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op2_q         <= op2_d;
      in_ready_q    <= in_ready_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      spurious_q    <= spurious_d;
      txn_count_q   <= txn_count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_code     = rsp_code_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign spurious     = spurious_q;
  assign txn_count    = txn_count_q;

endmodule

// File: tb/tb_calc_req_sequencer.sv
// Directed bench for calc_req_sequencer; the bench plays the calc1 port and the consumer.
module tb_calc_req_sequencer;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  calc_resp = '0;
  logic [31:0] calc_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        spurious;
  logic [15:0] txn_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  calc_req_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .req_cmd_out (req_cmd_out),
    .req_data_out(req_data_out),
    .calc_resp   (calc_resp),
    .calc_data   (calc_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_code    (rsp_code),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .spurious    (spurious),
    .txn_count   (txn_count)
  );

  always #5 c_clk = ~c_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Offer a transaction and follow it across the two port cycles into WAIT_RESP.
  task automatic send(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                      input logic [31:0] op2);
    check_eq({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_op1   = op1;
    in_op2   = op2;
    tick();
    in_valid = 1'b0;
    in_cmd   = '0;
    in_op1   = '0;
    in_op2   = '0;
    check_eq({tag, ".ready_low"}, 32'(in_ready), 32'd0);
    check_eq({tag, ".p1_cmd"}, 32'(req_cmd_out), 32'(cmd));
    check_eq({tag, ".p1_data"}, req_data_out, op1);
    tick();
    check_eq({tag, ".p2_cmd"}, 32'(req_cmd_out), 32'd0);
    check_eq({tag, ".p2_data"}, req_data_out, op2);
    tick();
    check_eq({tag, ".w_cmd"}, 32'(req_cmd_out), 32'd0);
    check_eq({tag, ".w_data"}, req_data_out, 32'd0);
  endtask

  task automatic respond(input string tag, input logic [1:0] code, input logic [31:0] data);
    calc_resp = code;
    calc_data = data;
    tick();
    calc_resp = '0;
    calc_data = '0;
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, ".code"}, 32'(rsp_code), 32'(code));
    check_eq({tag, ".data"}, rsp_data, data);
    check_eq({tag, ".tmo"}, 32'(rsp_timeout), 32'd0);
  endtask

  task automatic handshake(input string tag, input logic [15:0] exp_cnt);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, ".hs_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".hs_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".hs_tmo"}, 32'(rsp_timeout), 32'd0);
    check_eq({tag, ".hs_cnt"}, 32'(txn_count), 32'(exp_cnt));
  endtask

  initial begin
    #1 reset = 1'b0;
    tick();
    tick();
    check_eq("rst.ready", 32'(in_ready), 32'd0);
    check_eq("rst.cmd", 32'(req_cmd_out), 32'd0);
    check_eq("rst.data", req_data_out, 32'd0);
    check_eq("rst.valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.cnt", 32'(txn_count), 32'd0);
    check_eq("rst.spur", 32'(spurious), 32'd0);
    reset = 1'b1;
    check_eq("rel.ready_pre", 32'(in_ready), 32'd0);
    tick();
    check_eq("rel.ready", 32'(in_ready), 32'd1);

    send("add", 4'd1, 32'h5, 32'h7);
    respond("add", 2'd1, 32'hC);
    handshake("add", 16'd1);

    send("ovf", 4'd1, 32'hFFFF_FFFF, 32'h1);
    respond("ovf", 2'd2, 32'h0);
    handshake("ovf", 16'd2);

    send("shl", 4'd5, 32'h1, 32'd4);
    respond("shl", 2'd1, 32'h10);
    handshake("shl", 16'd3);

    // Timeout: 8 edges in WAIT_RESP with no response.
    send("tmo", 4'd2, 32'h9, 32'h3);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("tmo.not_yet", 32'(rsp_valid), 32'd0);
    end
    tick();
    check_eq("tmo.valid", 32'(rsp_valid), 32'd1);
    check_eq("tmo.flag", 32'(rsp_timeout), 32'd1);
    check_eq("tmo.code", 32'(rsp_code), 32'd0);
    check_eq("tmo.data", rsp_data, 32'd0);
    handshake("tmo", 16'd4);

    // Response arriving on the limit edge beats the timeout.
    send("win", 4'd6, 32'h80, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    check_eq("win.not_yet", 32'(rsp_valid), 32'd0);
    respond("win", 2'd1, 32'h55);
    handshake("win", 16'd5);

    // No-op: consumed, nothing reaches the port, no response.
    in_valid = 1'b1;
    in_cmd   = 4'd0;
    in_op1   = 32'hDEAD_BEEF;
    in_op2   = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    in_op1   = '0;
    in_op2   = '0;
    check_eq("nop.ready", 32'(in_ready), 32'd1);
    check_eq("nop.cmd", 32'(req_cmd_out), 32'd0);
    check_eq("nop.data", req_data_out, 32'd0);
    tick();
    tick();
    check_eq("nop.data2", req_data_out, 32'd0);
    check_eq("nop.valid", 32'(rsp_valid), 32'd0);
    check_eq("nop.cnt", 32'(txn_count), 32'd5);

    // Back-pressure: response must hold for 5 cycles with rsp_ready low.
    send("bp", 4'd1, 32'h2, 32'h3);
    respond("bp", 2'd1, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp.valid", 32'(rsp_valid), 32'd1);
      check_eq("bp.code", 32'(rsp_code), 32'd1);
      check_eq("bp.data", rsp_data, 32'h5);
      check_eq("bp.ready", 32'(in_ready), 32'd0);
      check_eq("bp.cnt", 32'(txn_count), 32'd5);
    end
    handshake("bp", 16'd6);
    tick();
    check_eq("bp.cnt_once", 32'(txn_count), 32'd6);
    check_eq("bp.spur_clean", 32'(spurious), 32'd0);

    // Spurious response in IDLE: sticky, and no capture.
    calc_resp = 2'd1;
    calc_data = 32'hABCD;
    tick();
    calc_resp = '0;
    calc_data = '0;
    check_eq("spur.set", 32'(spurious), 32'd1);
    check_eq("spur.no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    check_eq("spur.sticky", 32'(spurious), 32'd1);

    // Asynchronous reset mid WAIT_RESP.
    send("rw", 4'd1, 32'h11, 32'h22);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rw.ready", 32'(in_ready), 32'd0);
    check_eq("rw.cnt", 32'(txn_count), 32'd0);
    check_eq("rw.spur", 32'(spurious), 32'd0);
    check_eq("rw.valid", 32'(rsp_valid), 32'd0);
    check_eq("rw.cmd", 32'(req_cmd_out), 32'd0);
    tick();
    reset = 1'b1;
    check_eq("rw.ready_pre", 32'(in_ready), 32'd0);
    tick();
    check_eq("rw.ready_post", 32'(in_ready), 32'd1);
    tick();
    check_eq("rw.no_rsp", 32'(rsp_valid), 32'd0);

    send("post", 4'd1, 32'h10, 32'h20);
    respond("post", 2'd1, 32'h30);
    handshake("post", 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_req_sequencer.md
# calc_req_sequencer

Per-port request sequencer that sits directly upstream of one request port of `calc1_top`. It accepts a complete calculator transaction (command plus both operands) on a valid/ready interface and serialises it onto the port's two-cycle `reqN_cmd_in`/`reqN_data_in` protocol. It then waits for the port's `out_respN`/`out_dataN` response and returns it, or a timeout, on a valid/ready response interface. Four instances drive the four calculator ports, with one transaction outstanding per port.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles spent in WAIT_RESP before a timeout response is produced; legal range is 2 or more.
- `c_clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — transaction offered.
- `in_ready`  out  1  — sequencer can accept a transaction.
- `in_cmd`  in  4  — command: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; other values are forwarded unchanged.
- `in_op1`, `in_op2`  in  32 each  — operands.
- `req_cmd_out`  out  4  — to `reqN_cmd_in`.
- `req_data_out`  out  32  — to `reqN_data_in`.
- `calc_resp`  in  2  — from `out_respN`.
- `calc_data`  in  32  — from `out_dataN`.
- `rsp_valid`  out  1  — response available.
- `rsp_ready`  in  1  — consumer accepts the response.
- `rsp_code`  out  2  — captured response code, or 0 on timeout.
- `rsp_data`  out  32  — captured data, or 0 on timeout.
- `rsp_timeout`  out  1  — qualifies `rsp_valid`; set when the response is a timeout.
- `spurious`  out  1  — sticky; set if `calc_resp` is nonzero outside WAIT_RESP.
- `txn_count`  out  16  — completed response handshakes; wraps 0xFFFF→0x0000.

## Operation
- States are IDLE, SEND_OP1, SEND_OP2, WAIT_RESP and HOLD_RESP.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&`in_ready` with `in_cmd`≠0: latch cmd, op1 and op2, then go to SEND_OP1.
  - On accept with `in_cmd`=0: consume and discard; produce no DUT activity and no response; stay in IDLE.
- **SEND_OP1:** `req_cmd_out`=cmd, `req_data_out`=op1 for exactly one cycle, then go to SEND_OP2.
- **SEND_OP2:** `req_cmd_out`=0, `req_data_out`=op2 for one cycle, then go to WAIT_RESP and clear the timer.
- **WAIT_RESP:** `req_cmd_out`=0, `req_data_out`=0, and the timer increments each cycle.
  - If `calc_resp`≠0: capture `calc_resp`/`calc_data` into `rsp_code`/`rsp_data`, then go to HOLD_RESP.
  - Else if timer = TIMEOUT_CYCLES−1: set `rsp_code`=0, `rsp_data`=0, `rsp_timeout`=1, then go to HOLD_RESP.
  - If a response and the timeout limit occur on the same edge, the response wins and `rsp_timeout`=0.
- **HOLD_RESP:** `rsp_valid`=1, with `rsp_code`, `rsp_data` and `rsp_timeout` held stable.
  - On `rsp_valid`&`rsp_ready`: increment `txn_count`, clear `rsp_timeout`, go to IDLE.
- `calc_resp` is ignored for capture outside WAIT_RESP; any nonzero value there sets `spurious`, which is cleared only by reset.
- The timer is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE.
  - `in_ready`=0; it rises on the first edge after `reset` deasserts.
  - All other outputs are 0: `req_cmd_out`, `req_data_out`, `rsp_valid`, `rsp_code`, `rsp_data`, `rsp_timeout`, `spurious`, `txn_count`.
- Accept at edge k:
  - `in_ready` falls after edge k.
  - cmd/op1 are on the port during cycle k+1.
  - op2 is on the port during cycle k+2.
  - WAIT_RESP starts at cycle k+3.
- A response sampled at edge m gives `rsp_valid`=1 from m until the handshake edge.
- Handshake at edge j: `rsp_valid`=0 and `in_ready`=1 after j. The minimum accept-to-accept spacing is therefore 5 cycles plus DUT latency.
- Asserting `reset` in any state immediately zeroes all outputs and returns to IDLE. The in-flight transaction is dropped without a response, and the bench resets `calc1_top` concurrently.

## Structure
- Shared package `calc_pkg` holds:
  - the `calc_cmd_e` enum (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6);
  - the `calc_resp_e` enum (RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_INT=3);
  - the `seq_state_e` state enum;
  - the command, data and response width constants (4, 32, 2).
- Single module, no sub-modules. The four-port wrapper is a separate generate-based block.

## Test plan
- **Add:** cmd 1, op1 0x5, op2 0x7 → port sees (1,0x5) then (0,0x7); `rsp_code`=1, `rsp_data`=0xC, `txn_count`=1.
- **Overflow:** cmd 1, op1 0xFFFFFFFF, op2 0x1 → `rsp_code`=2, `rsp_timeout`=0.
- **Shift left:** cmd 5, op1 0x1, op2 4 → `rsp_data`=0x10, `rsp_code`=1.
- **Timeout:** TIMEOUT_CYCLES=8 with `calc_resp` held at 0 → `rsp_valid` rises 8 cycles after WAIT_RESP entry with `rsp_timeout`=1 and `rsp_code`=0. Repeat with `calc_resp`=1 on the limit edge → `rsp_timeout`=0 (response wins).
- **No-op and back-pressure:** cmd 0 → no port activity and no response. Then an add with `rsp_ready` held low for 5 cycles → `rsp_*` stable throughout, `in_ready`=0 throughout, single `txn_count` increment.
- **Reset and spurious:** `reset` low during WAIT_RESP → all outputs 0 immediately, `in_ready`=1 one edge after release. Separately, `calc_resp`=1 in IDLE → `spurious`=1 and it stays set.
